// File: rtl/grain_prog_pkg.sv
// Shared constants for the GrainFlex programming sequencer: FSM state codes and
// CRC-16/CCITT parameters used by the optional readback CRC.
package grain_prog_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t PRST = 2'd1;
    localparam state_t LOAD = 2'd2;
    localparam state_t FIN  = 2'd3;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
        return (crc[15] ^ b) ? ({crc[14:0], 1'b0} ^ CRC_POLY) : {crc[14:0], 1'b0};
    endfunction

endpackage

// File: rtl/grain_prog_crc16.sv
// Bit-serial CRC-16/CCITT over the readback stream; clr loads the init value,
// en folds in one bit. Reset value is 0 so rb_crc reads 0 out of reset.
module grain_prog_crc16
    import grain_prog_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    input  logic        bit_in,
    output logic [15:0] crc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            crc <= '0;
        else if (clr)
            crc <= CRC_INIT;
        else if (en)
            crc <= crc16_step(crc, bit_in);
    end

endmodule

// File: rtl/grain_prog_sequencer.sv
// Serial configuration sequencer: byte stream in, prog_rst pulse, then CHAIN_BITS
// bits LSB-first on prog_clk/prog_en/prog_din. Readback CRC under GRAIN_PROG_READBACK_CRC_EN.
module grain_prog_sequencer
    import grain_prog_pkg::*;
#(
    parameter int CHAIN_BITS = 256,
    parameter int CLK_DIV    = 2,
    parameter int RST_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic        prog_clk,
    output logic        prog_rst,
    output logic        prog_en,
    output logic        prog_din,
    input  logic        prog_dout,
    output logic        busy,
    output logic        done,
    output logic [15:0] rb_crc
);

    localparam int NBYTES = (CHAIN_BITS + 7) / 8;
    localparam int BW     = $clog2(CHAIN_BITS + 1);
    localparam int YW     = $clog2(NBYTES + 1);
    localparam int DW     = $clog2(CLK_DIV + 1);
    localparam int RW     = $clog2(RST_CYCLES + 1);

    state_t        state_q, state_d;
    logic [RW-1:0] rst_cnt_q, rst_cnt_d;
    logic [DW-1:0] div_q, div_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic [YW-1:0] byte_cnt_q, byte_cnt_d;
    logic [7:0]    hold_q, hold_d;
    logic [2:0]    idx_q, idx_d;
    logic          hold_vld_q, hold_vld_d;
    logic          active_q, active_d;
    logic          s_ready_d, prog_clk_d, prog_rst_d, prog_en_d, prog_din_d, busy_d, done_d;
    logic          start_bit, crc_clr, crc_en;

    always_comb begin
        state_d    = state_q;
        rst_cnt_d  = rst_cnt_q;
        div_d      = div_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        hold_d     = hold_q;
        idx_d      = idx_q;
        hold_vld_d = hold_vld_q;
        active_d   = active_q;
        prog_clk_d = prog_clk;
        prog_rst_d = prog_rst;
        prog_en_d  = prog_en;
        prog_din_d = prog_din;
        done_d     = 1'b0;
        start_bit  = 1'b0;
        crc_clr    = 1'b0;
        crc_en     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d    = PRST;
                    prog_rst_d = 1'b1;
                    rst_cnt_d  = '0;
                    div_d      = '0;
                    bit_cnt_d  = '0;
                    byte_cnt_d = '0;
                    hold_d     = '0;
                    idx_d      = '0;
                    hold_vld_d = 1'b0;
                    active_d   = 1'b0;
                    crc_clr    = 1'b1;
                end
            end
            PRST: begin
                if (rst_cnt_q == RW'(RST_CYCLES - 1)) begin
                    state_d    = LOAD;
                    prog_rst_d = 1'b0;
                    prog_en_d  = 1'b1;
                end else begin
                    rst_cnt_d = rst_cnt_q + 1'b1;
                end
            end
            LOAD: begin
                if (s_valid && s_ready) begin
                    hold_d     = s_data;
                    hold_vld_d = 1'b1;
                    byte_cnt_d = byte_cnt_q + 1'b1;
                end
                // active_q=0 is the stall: prog_clk parked low until a bit is held
                if (!active_q) begin
                    start_bit = hold_vld_q;
                end else if (div_q != DW'(CLK_DIV - 1)) begin
                    div_d = div_q + 1'b1;
                end else if (!prog_clk) begin
                    prog_clk_d = 1'b1;
                    div_d      = '0;
                    bit_cnt_d  = bit_cnt_q + 1'b1;
                    crc_en     = 1'b1;
                end else begin
                    prog_clk_d = 1'b0;
                    div_d      = '0;
                    if (bit_cnt_q == BW'(CHAIN_BITS)) begin
                        state_d   = FIN;
                        prog_en_d = 1'b0;
                        done_d    = 1'b1;
                        active_d  = 1'b0;
                    end else if (hold_vld_q) begin
                        start_bit = 1'b1;
                    end else begin
                        active_d = 1'b0;
                    end
                end
                if (start_bit) begin
                    prog_din_d = hold_q[idx_q];
                    idx_d      = idx_q + 1'b1;
                    active_d   = 1'b1;
                    div_d      = '0;
                    // last bit of the chain drops whatever is left of the byte
                    if (idx_q == 3'd7 || bit_cnt_q == BW'(CHAIN_BITS - 1)) begin
                        hold_vld_d = 1'b0;
                        idx_d      = '0;
                    end
                end
            end
            FIN: begin
                state_d    = IDLE;
                prog_din_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase

        if (abort && state_q != IDLE) begin
            state_d    = IDLE;
            prog_clk_d = 1'b0;
            prog_rst_d = 1'b0;
            prog_en_d  = 1'b0;
            prog_din_d = 1'b0;
            done_d     = 1'b0;
            hold_vld_d = 1'b0;
            active_d   = 1'b0;
            crc_en     = 1'b0;
        end

        busy_d    = (state_d != IDLE);
        s_ready_d = (state_d == LOAD) && !hold_vld_d && (byte_cnt_d < YW'(NBYTES));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rst_cnt_q  <= '0;
            div_q      <= '0;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            hold_q     <= '0;
            idx_q      <= '0;
            hold_vld_q <= 1'b0;
            active_q   <= 1'b0;
            s_ready    <= 1'b0;
            prog_clk   <= 1'b0;
            prog_rst   <= 1'b0;
            prog_en    <= 1'b0;
            prog_din   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_q    <= state_d;
            rst_cnt_q  <= rst_cnt_d;
            div_q      <= div_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            hold_q     <= hold_d;
            idx_q      <= idx_d;
            hold_vld_q <= hold_vld_d;
            active_q   <= active_d;
            s_ready    <= s_ready_d;
            prog_clk   <= prog_clk_d;
            prog_rst   <= prog_rst_d;
            prog_en    <= prog_en_d;
            prog_din   <= prog_din_d;
            busy       <= busy_d;
            done       <= done_d;
        end
    end

`ifdef GRAIN_PROG_READBACK_CRC_EN
    grain_prog_crc16 u_crc (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (crc_clr),
        .en     (crc_en),
        .bit_in (prog_dout),
        .crc    (rb_crc)
    );
`else
    logic unused_crc;
    assign unused_crc = ^{crc_clr, crc_en, prog_dout};
    assign rb_crc     = '0;
`endif

endmodule

// File: tb/tb_grain_prog_sequencer.sv
// Randomized self-checking bench for grain_prog_sequencer (12-bit chain, CLK_DIV=2).
module tb_grain_prog_sequencer;

    localparam int NB = 12;
    localparam int D  = 2;
    localparam int R  = 4;

    logic        clk = 1'b0;
    logic        rst_n, start, abort, s_valid, prog_dout;
    logic [7:0]  s_data;
    logic        s_ready, prog_clk, prog_rst, prog_en, prog_din, busy, done;
    logic [15:0] rb_crc;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    grain_prog_sequencer #(.CHAIN_BITS(NB), .CLK_DIV(D), .RST_CYCLES(R)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .prog_clk  (prog_clk),
        .prog_rst  (prog_rst),
        .prog_en   (prog_en),
        .prog_din  (prog_din),
        .prog_dout (prog_dout),
        .busy      (busy),
        .done      (done),
        .rb_crc    (rb_crc)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // CRC-16/CCITT, MSB-first shift register, over the first n readback bits
    function automatic logic [15:0] crc_ref(input logic [15:0] bits, input int n);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 0; i < n; i++)
            c = (c[15] ^ bits[i]) ? ((c << 1) ^ 16'h1021) : (c << 1);
        return c;
    endfunction

    // gap_mode: 0 back-to-back, 1 random gaps, 2 long stall before second byte
    task automatic run_seq(input logic [7:0] b0, input logic [7:0] b1, input logic [15:0] rb,
                           input int gap_mode, input int abort_at, input int rst_at,
                           input bit start_mid);
        logic [NB-1:0] din_seq, exp_seq;
        logic [7:0]    bytes [2];
        int  nrise, ndone, nrst_rise, rst_hi, hi_len, stable, bidx, gap;
        bit  prev_clk, prev_rst, prev_din, ready_q, in_load, fin, ended, mid_started;
        bytes[0] = b0; bytes[1] = b1;
        din_seq = '0;
        nrise = 0; ndone = 0; nrst_rise = 0; rst_hi = 0; hi_len = 0; stable = 0; bidx = 0; gap = 0;
        prev_clk = 0; prev_rst = 0; prev_din = 0; ready_q = 0; in_load = 0;
        fin = 0; ended = 0; mid_started = 0;

        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("prst_first", prog_rst, 1'b1);

        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc > 0) @(negedge clk);
            start = 1'b0;
            if (prog_rst) rst_hi++;
            if (prog_rst && !prev_rst) nrst_rise++;
            chk("en_in_prst", prog_rst & prog_en, 1'b0);
            if (prev_rst && !prog_rst) in_load = 1;
            chk("busy", busy, 1'b1);
            if (done) begin
                ndone++;
                in_load = 0;
                fin = 1;
                chk("fin_outs", {prog_clk, prog_en, prog_rst}, 3'b000);
            end
            if (in_load) chk("en_hold", prog_en, 1'b1);
            if (prog_din != prev_din) begin
                chk("din_edge", prog_clk, 1'b0);
                stable = 1;
            end else begin
                stable++;
            end
            if (prog_clk && !prev_clk) begin
                chk("setup", stable > D, 1'b1);
                if (nrise < NB) din_seq[nrise] = prog_din;
                nrise++;
            end
            if (prog_clk) hi_len++;
            else begin
                if (prev_clk) chk("hi_len", hi_len, D);
                hi_len = 0;
            end

            if (fin) begin
                @(negedge clk);
                chk("idle_after", {busy, done, prog_din, prog_clk, s_ready}, 5'b0);
                ended = 1;
                break;
            end
            if (abort_at >= 0 && nrise == abort_at) begin
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0; s_valid = 1'b0;
                chk("abort_outs", {prog_clk, prog_rst, prog_en, prog_din, busy, s_ready, done}, 7'b0);
                repeat (8) begin
                    @(negedge clk);
                    if (done) ndone++;
                end
                chk("abort_nodone", ndone, 0);
                ended = 1;
                break;
            end
            if (rst_at >= 0 && nrise == rst_at) begin
                #1 rst_n = 1'b0;
                #1;
                chk("async_rst", {prog_clk, prog_rst, prog_en, prog_din, busy, s_ready, done, rb_crc}, 23'b0);
                s_valid = 1'b0;
                @(negedge clk); rst_n = 1'b1;
                ended = 1;
                break;
            end

            if (start_mid && nrise == 3 && !mid_started) begin
                start = 1'b1;
                mid_started = 1;
            end
            if (s_valid && ready_q) begin
                bidx++;
                if (gap_mode == 2 && bidx == 1) gap = 20 + 8 * 2 * D;
                else if (gap_mode == 1) gap = int'($urandom_range(0, 5));
                else gap = 0;
            end
            chk("no_extra_ready", s_ready & (bidx >= 2), 1'b0);
            if (gap_mode == 2 && bidx == 1 && gap > 0 && gap < 12)
                chk("stall_pins", {prog_clk, prog_en, 4'(nrise)}, {2'b01, 4'd8});
            if (gap > 0) begin
                s_valid = 1'b0;
                gap--;
            end else if (bidx < 2) begin
                s_valid = 1'b1;
                s_data  = bytes[bidx];
            end else begin
                s_valid = 1'b0;
            end
            ready_q   = s_ready;
            prog_dout = (nrise < 16) ? rb[nrise] : 1'b0;
            prev_clk  = prog_clk;
            prev_rst  = prog_rst;
            prev_din  = prog_din;
        end
        chk("timeout", ended, 1'b1);
        s_valid = 1'b0;

        if (abort_at < 0 && rst_at < 0) begin
            for (int i = 0; i < NB; i++) exp_seq[i] = bytes[i / 8][i % 8];
            chk("din_seq", din_seq, exp_seq);
            chk("nrise", nrise, NB);
            chk("ndone", ndone, 1);
            chk("prst_len", rst_hi, R);
            chk("prst_cnt", nrst_rise, 1);
`ifdef GRAIN_PROG_READBACK_CRC_EN
            chk("rb_crc", rb_crc, crc_ref(rb, NB));
`else
            chk("rb_crc", rb_crc, 16'h0);
`endif
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        s_valid = 1'b0; s_data = '0; prog_dout = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outs", {s_ready, prog_clk, prog_rst, prog_en, prog_din, busy, done, rb_crc}, 23'b0);
        rst_n = 1'b1;
        @(negedge clk);

        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        chk("start_abort_idle", {busy, prog_rst}, 2'b00);

        run_seq(8'hA5, 8'h3C, 16'h0FFF, 0, -1, -1, 1'b1);
        run_seq(8'hA5, 8'h3C, 16'h0FFF, 2, -1, -1, 1'b0);
        run_seq(8'h5A, 8'hC3, 16'h1234, 1, 5, -1, 1'b0);
        run_seq(8'h96, 8'h0F, 16'hBEEF, 0, -1, -1, 1'b0);
        run_seq(8'hFF, 8'h00, 16'h0000, 1, -1, 6, 1'b0);
        run_seq(8'h01, 8'h80, 16'hFFFF, 0, -1, -1, 1'b0);
        for (int k = 0; k < 6; k++)
            run_seq(8'($urandom), 8'($urandom), 16'($urandom), 1, -1, -1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/grain_prog_sequencer.md
# grain_prog_sequencer

Programming sequencer for the GrainFlex fabric's serial configuration interface. Accepts a byte-wide bitstream over a valid/ready stream, pulses the fabric programming reset, then serialises `CHAIN_BITS` bits LSB-first onto the programming clock, enable and data lines. It replaces manual bit-banging of the programming pins and sits between a host-side byte source and the fabric's programming interface.

## Interface
- `CHAIN_BITS`, 256: configuration chain length in bits (≥1)
- `CLK_DIV`, 2: `clk` cycles per half-period of `prog_clk` (≥1)
- `RST_CYCLES`, 4: `clk` cycles `prog_rst` is held high (≥1)

- `clk`  in  1  system clock; all logic on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle request to begin programming; honoured only in IDLE
- `abort`  in  1  terminate an in-flight programming sequence
- `s_data`  in  8  bitstream byte, bit 0 shifted first
- `s_valid`  in  1  `s_data` valid
- `s_ready`  out  1  byte accepted when `s_valid & s_ready`
- `prog_clk`  out  1  fabric programming clock
- `prog_rst`  out  1  fabric programming reset, active high
- `prog_en`  out  1  fabric programming enable
- `prog_din`  out  1  serial config data to fabric
- `prog_dout`  in  1  serial data shifted out of fabric chain
- `busy`  out  1  high in any state except IDLE
- `done`  out  1  one-cycle pulse on normal completion
- `rb_crc`  out  16  readback CRC (only with `GRAIN_PROG_READBACK_CRC_EN`, else tied 0)

## Operation
- All outputs registered; reset value of every output is 0.
- States: IDLE → PRST → LOAD → FIN → IDLE.
- IDLE: outputs low. `start` → PRST; bit counter, byte buffer and CRC cleared.
- PRST: `prog_rst`=1, `prog_en`=0 for exactly `RST_CYCLES` cycles, then → LOAD.
- LOAD: `prog_en`=1. A one-byte holding register plus 3-bit index feeds `prog_din`. `s_ready`=1 only when in LOAD, the holding register is empty, and bits remain. A bit period starts only when a bit is available; otherwise `prog_clk` stays low and the phase counter holds (stall; `prog_en` remains 1).
- Bit counter counts rising `prog_clk` edges; after the `CHAIN_BITS`-th high phase completes → FIN. Unused high bits of the final byte are discarded; no further bytes are accepted.
- FIN: one cycle, `prog_en`=0, `prog_clk`=0, `done`=1, → IDLE.
- `abort` in any non-IDLE state: next cycle → IDLE, all prog outputs 0, no `done`. `abort` takes priority over every transition, including the cycle that would enter FIN.
- `start` while busy: ignored. `start` and `abort` together in IDLE: `abort` wins; remain IDLE.
- `rst_n` low mid-sequence: immediate return to IDLE with all outputs 0; a partially accepted byte is lost.

## Timing
- `start` sampled at edge T → `prog_rst` high from T+1 through T+`RST_CYCLES`.
- Bit period = 2·`CLK_DIV` cycles: `prog_clk` low for `CLK_DIV` cycles, then high for `CLK_DIV` cycles.
- `prog_din` changes only on the edge that drives `prog_clk` low, giving `CLK_DIV` cycles of setup.
- `prog_dout` sampled on the `clk` edge that drives `prog_clk` high.
- Byte accepted at edge E → its bit 0 appears on `prog_din` no earlier than E+1.
- Unstalled total duration: `RST_CYCLES` + 2·`CLK_DIV`·`CHAIN_BITS` + 1 (FIN).

## Configuration
- `GRAIN_PROG_READBACK_CRC_EN` defined: CRC-16/CCITT (poly 0x1021, init 0xFFFF, non-reflected) is updated with each sampled `prog_dout` bit during LOAD. `rb_crc` is held stable from FIN until the next `start`; it is cleared on reset and on `start`.
- Undefined: no CRC logic; `rb_crc` tied to 0.

## Structure
- Package `grain_prog_pkg`: state enum (IDLE, PRST, LOAD, FIN), CRC polynomial and init constants.
- Sub-module `grain_prog_crc16`: bit-serial CRC with `clr`/`en`/`bit` inputs; instantiated only under the macro.

## Test plan
- `CHAIN_BITS`=12, `CLK_DIV`=2; send 0xA5, 0x3C → `prog_din` at the 12 rising edges = 1,0,1,0,0,1,0,1,0,0,1,1; exactly 12 `prog_clk` pulses; `done` once; second byte's upper nibble discarded.
- Withhold `s_valid` for 20 cycles after the first byte → `prog_clk` low during the stall, `prog_en` held 1, bit sequence unchanged.
- `abort` after 5 bits → next cycle all prog outputs 0, `busy`=0, no `done`; a fresh `start` completes normally.
- `rst_n` low mid-LOAD → all outputs 0 asynchronously; `start` during LOAD ignored (no second PRST).
- With the macro, fabric model returns 0xFF then 0x0F on `prog_dout` → `rb_crc` equals the reference CRC of those 12 bits; without the macro, `rb_crc`=0.
- `RST_CYCLES`=4: `prog_rst` high exactly 4 cycles, starting one cycle after `start`, with `prog_en`=0 throughout.
